// File: rtl/inertial_sequencer.sv
// Inertial sensor sequencer: power-up wait, four config writes, then a four-register
// burst read per data-ready interrupt, delivering pitch rate and Z accel with a vld pulse.
module inertial_sequencer #(
    parameter int          INIT_WAIT_W = 16,
    parameter logic [15:0] CFG0        = 16'h0D02,
    parameter logic [15:0] CFG1        = 16'h1053,
    parameter logic [15:0] CFG2        = 16'h1150,
    parameter logic [15:0] CFG3        = 16'h1460
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    typedef enum logic [1:0] {
        PWR_WAIT = 2'd0,
        CFG_WR   = 2'd1,
        IDLE     = 2'd2,
        RD       = 2'd3
    } state_e;

    localparam logic [INIT_WAIT_W-1:0] CNT_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [INIT_WAIT_W-1:0] cnt_q, cnt_d;
    logic                   int_meta_q, int_s_q;
    logic                   spi_wrt_q, spi_wrt_d;
    logic [15:0]            spi_cmd_q, spi_cmd_d;
    logic [15:0]            ptch_rt_q, ptch_rt_d;
    logic [15:0]            az_q, az_d;
    logic                   vld_q, vld_d;
    logic [7:0]             b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] n);
        case (n)
            2'd0:    cfg_cmd = CFG0;
            2'd1:    cfg_cmd = CFG1;
            2'd2:    cfg_cmd = CFG2;
            default: cfg_cmd = CFG3;
        endcase
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [1:0] n);
        case (n)
            2'd0:    rd_cmd = 16'hA200;
            2'd1:    rd_cmd = 16'hA300;
            2'd2:    rd_cmd = 16'hAC00;
            default: rd_cmd = 16'hAD00;
        endcase
    endfunction

    // Next-state, command issue and capture logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        spi_wrt_d = 1'b0;
        spi_cmd_d = spi_cmd_q;
        ptch_rt_d = ptch_rt_q;
        az_d      = az_q;
        vld_d     = 1'b0;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == {INIT_WAIT_W{1'b1}}) begin
                    spi_wrt_d = 1'b1;
                    spi_cmd_d = CFG0;
                    idx_d     = 2'd0;
                    state_d   = CFG_WR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CFG_WR: begin
                if (spi_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        spi_wrt_d = 1'b1;
                        spi_cmd_d = cfg_cmd(idx_q + 2'd1);
                    end
                end else begin
                    state_d = CFG_WR;
                end
            end
            IDLE: begin
                if (int_s_q) begin
                    spi_wrt_d = 1'b1;
                    spi_cmd_d = rd_cmd(2'd0);
                    idx_d     = 2'd0;
                    state_d   = RD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (spi_done) begin
                    case (idx_q)
                        2'd0:    b0_d = spi_rd_data[7:0];
                        2'd1:    b1_d = spi_rd_data[7:0];
                        2'd2:    b2_d = spi_rd_data[7:0];
                        default: b2_d = b2_q;
                    endcase
                    // The last byte goes straight to AZ; no need to stage it.
                    if (idx_q == 2'd3) begin
                        vld_d     = 1'b1;
                        ptch_rt_d = {b1_q, b0_q};
                        az_d      = {spi_rd_data[7:0], b2_q};
                        state_d   = IDLE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        spi_wrt_d = 1'b1;
                        spi_cmd_d = rd_cmd(idx_q + 2'd1);
                    end
                end else begin
                    state_d = RD;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    // State, staging and output registers with async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PWR_WAIT;
            idx_q      <= 2'd0;
            cnt_q      <= {INIT_WAIT_W{1'b0}};
            int_meta_q <= 1'b0;
            int_s_q    <= 1'b0;
            spi_wrt_q  <= 1'b0;
            spi_cmd_q  <= 16'h0000;
            ptch_rt_q  <= 16'h0000;
            az_q       <= 16'h0000;
            vld_q      <= 1'b0;
            b0_q       <= 8'h00;
            b1_q       <= 8'h00;
            b2_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            int_meta_q <= INT;
            int_s_q    <= int_meta_q;
            spi_wrt_q  <= spi_wrt_d;
            spi_cmd_q  <= spi_cmd_d;
            ptch_rt_q  <= ptch_rt_d;
            az_q       <= az_d;
            vld_q      <= vld_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
        end
    end

    assign spi_wrt = spi_wrt_q;
    assign spi_cmd = spi_cmd_q;
    assign ptch_rt = ptch_rt_q;
    assign AZ      = az_q;
    assign vld     = vld_q;

endmodule

// File: tb/tb_inertial_sequencer.sv
// Self-checking bench for inertial_sequencer: SPI slave model with a register map,
// event logs, and a command/data reference model driven by directed and random reads.
module tb_inertial_sequencer;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n, INT, spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_wrt, vld;
    logic [15:0] spi_cmd, ptch_rt, AZ;

    inertial_sequencer #(.INIT_WAIT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .spi_done(spi_done),
        .spi_rd_data(spi_rd_data), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] mem [0:255];
    int lat = 8;
    int spur_cnt = 0, spur_seen = 0;
    int hold_viol = 0, pulse_viol = 0;
    int          wrt_cyc_q[$];
    logic [15:0] wrt_cmd_q[$];
    int          done_cyc_q[$];
    int          vld_cyc_q[$];
    logic [15:0] vld_pt_q[$], vld_az_q[$];
    logic [15:0] exp_cmd_q[$], exp_pt_q[$], exp_az_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI slave: done 'lat' cycles after each wrt, read data from the register map
    initial begin : spi_model
        int          cd;
        logic [15:0] cmd;
        cd = 0;
        cmd = 16'h0000;
        spi_done = 1'b0;
        spi_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        spi_done = 1'b1;
                        spi_rd_data = {8'($urandom), mem[cmd[15:8]]};
                        done_cyc_q.push_back(cyc);
                    end
                end
                if (spi_wrt) begin
                    cd = lat;
                    cmd = spi_cmd;
                end
                if (cd == 0 && !spi_done && spur_seen != spur_cnt) begin
                    spi_done = 1'b1;
                    spi_rd_data = 16'($urandom);
                    spur_seen++;
                end
            end
        end
    end

    // Event logger and pulse/hold rule watcher
    initial begin : monitor
        logic [15:0] pp, pa, pc;
        logic        pv, pw;
        pp = 16'h0; pa = 16'h0; pc = 16'h0; pv = 1'b0; pw = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (spi_wrt) begin
                    wrt_cyc_q.push_back(cyc);
                    wrt_cmd_q.push_back(spi_cmd);
                end
                if (vld) begin
                    vld_cyc_q.push_back(cyc);
                    vld_pt_q.push_back(ptch_rt);
                    vld_az_q.push_back(AZ);
                end
                if (!vld && (ptch_rt !== pp || AZ !== pa)) hold_viol++;
                if (!spi_wrt && spi_cmd !== pc) hold_viol++;
                if ((vld && pv) || (spi_wrt && pw)) pulse_viol++;
            end
            pp = ptch_rt; pa = AZ; pc = spi_cmd; pv = vld; pw = spi_wrt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int done_after(input int c);
        foreach (done_cyc_q[i]) if (done_cyc_q[i] > c) return done_cyc_q[i];
        return -1;
    endfunction

    task automatic wait_vlds(input int target, input string tag);
        for (int i = 0; i < 800 && vld_cyc_q.size() < target; i++) @(negedge clk);
        chk(tag, vld_cyc_q.size(), target);
    endtask

    task automatic wait_wrts(input int target, input string tag);
        for (int i = 0; i < 800 && wrt_cyc_q.size() < target; i++) @(negedge clk);
        chk(tag, wrt_cyc_q.size(), target);
    endtask

    task automatic push_cfg();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    // Reference: four reads in register order, words assembled high:low
    task automatic push_read();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
        exp_pt_q.push_back({mem[8'hA3], mem[8'hA2]});
        exp_az_q.push_back({mem[8'hAD], mem[8'hAC]});
    endtask

    task automatic check_burst(input int wb, input int first_cyc, input string tag);
        chk({tag, "_first_wrt_cyc"}, wrt_cyc_q[wb], first_cyc);
        for (int j = 0; j < 4; j++) chk({tag, "_cmd"}, wrt_cmd_q[wb + j], exp_cmd_q[wb + j]);
        for (int j = 1; j < 4; j++)
            chk({tag, "_done_to_wrt"}, wrt_cyc_q[wb + j], done_after(wrt_cyc_q[wb + j - 1]) + 1);
    endtask

    task automatic check_vld(input int vb, input int wb, input string tag);
        chk({tag, "_ptch_rt"}, vld_pt_q[vb], exp_pt_q[vb]);
        chk({tag, "_AZ"}, vld_az_q[vb], exp_az_q[vb]);
        chk({tag, "_done_to_vld"}, vld_cyc_q[vb], done_after(wrt_cyc_q[wb + 3]) + 1);
    endtask

    task automatic set_bytes(input logic [7:0] a2, input logic [7:0] a3,
                             input logic [7:0] ac, input logic [7:0] ad);
        mem[8'hA2] = a2; mem[8'hA3] = a3; mem[8'hAC] = ac; mem[8'hAD] = ad;
    endtask

    task automatic do_read(input int hold, input string tag);
        int wb, vb, i0;
        wb = wrt_cyc_q.size();
        vb = vld_cyc_q.size();
        push_read();
        i0 = cyc;
        INT = 1'b1;
        cycles(hold);
        INT = 1'b0;
        wait_vlds(vb + 1, {tag, "_vld_seen"});
        cycles(2);
        check_burst(wb, i0 + 3, tag);
        check_vld(vb, wb, tag);
        chk({tag, "_hold_after"}, ptch_rt, exp_pt_q[vb]);
    endtask

    initial begin : main
        int rel, wb, vb, db, i0;
        rst_n = 1'b0;
        INT = 1'b0;
        cycles(3);
        chk("rst_spi_wrt", spi_wrt, 0);
        chk("rst_spi_cmd", spi_cmd, 0);
        chk("rst_ptch_rt", ptch_rt, 0);
        chk("rst_AZ", AZ, 0);
        chk("rst_vld", vld, 0);

        // Power-up wait and config sequence
        rst_n = 1'b1;
        rel = cyc;
        push_cfg();
        wait_wrts(4, "cfg_wrts_seen");
        cycles(30);
        check_burst(0, rel + 16, "cfg");
        chk("cfg_no_extra_wrt", wrt_cyc_q.size(), 4);
        chk("cfg_no_vld", vld_cyc_q.size(), 0);

        // Directed reads, including signed extremes
        set_bytes(8'h34, 8'h12, 8'hCD, 8'hAB);
        do_read(1, "rd1");
        cycles(5);
        set_bytes(8'h00, 8'h80, 8'hFF, 8'h7F);
        do_read(1, "rd2_extremes");

        // Level INT held across a burst: exactly one back-to-back re-read
        set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        wb = wrt_cyc_q.size();
        vb = vld_cyc_q.size();
        push_read();
        push_read();
        i0 = cyc;
        INT = 1'b1;
        wait_vlds(vb + 1, "lvl_vld1_seen");
        INT = 1'b0;
        wait_vlds(vb + 2, "lvl_vld2_seen");
        cycles(30);
        check_burst(wb, i0 + 3, "lvl1");
        check_burst(wb + 4, vld_cyc_q[vb] + 1, "lvl2");
        check_vld(vb, wb, "lvl1");
        check_vld(vb + 1, wb + 4, "lvl2");
        chk("lvl_no_third_burst", wrt_cyc_q.size(), exp_cmd_q.size());
        chk("lvl_vld_count", vld_cyc_q.size(), vb + 2);

        // Spurious done while idle
        wb = wrt_cyc_q.size();
        vb = vld_cyc_q.size();
        spur_cnt++;
        cycles(12);
        chk("spur_idle_no_wrt", wrt_cyc_q.size(), wb);
        chk("spur_idle_no_vld", vld_cyc_q.size(), vb);
        chk("spur_idle_ptch_rt", ptch_rt, exp_pt_q[vb - 1]);
        chk("spur_idle_AZ", AZ, exp_az_q[vb - 1]);

        // Randomized reads with varying SPI latency and INT width
        for (int r = 0; r < 5; r++) begin
            set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            lat = $urandom_range(2, 10);
            do_read($urandom_range(1, 3), "rnd");
            cycles($urandom_range(1, 6));
        end

        // Reset in the middle of a read
        lat = 8;
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        vb = vld_cyc_q.size();
        db = done_cyc_q.size();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        INT = 1'b1;
        cycles(1);
        INT = 1'b0;
        for (int i = 0; i < 200 && done_cyc_q.size() < db + 2; i++) @(negedge clk);
        chk("mid_rd_a300_done_seen", done_cyc_q.size(), db + 2);
        cycles(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_spi_wrt", spi_wrt, 0);
        chk("mid_rst_spi_cmd", spi_cmd, 0);
        chk("mid_rst_ptch_rt", ptch_rt, 0);
        chk("mid_rst_AZ", AZ, 0);
        chk("mid_rst_vld", vld, 0);
        cycles(3);
        rst_n = 1'b1;
        rel = cyc;
        wb = exp_cmd_q.size();
        push_cfg();
        cycles(5);
        spur_cnt++;
        wait_wrts(wb + 4, "re_cfg_wrts_seen");
        cycles(30);
        chk("mid_rst_aborted_wrts", wb, wrt_cyc_q.size() - 4);
        check_burst(wb, rel + 16, "re_cfg");
        chk("mid_rst_no_vld", vld_cyc_q.size(), vb);
        chk("re_cfg_ptch_rt_zero", ptch_rt, 0);

        set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        do_read(2, "post_rst");
        cycles(10);

        chk("total_wrt_count", wrt_cyc_q.size(), exp_cmd_q.size());
        chk("hold_rule_violations", hold_viol, 0);
        chk("pulse_width_violations", pulse_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inertial_sequencer.md
Name: inertial_sequencer

Overview:
- Sequences the SPI inertial sensor and feeds the pitch integrator with raw pitch rate and Z-acceleration plus a single-cycle vld.
- After reset it waits for sensor power-up, then writes the sensor configuration registers.
- It then services each data-ready interrupt by reading four sensor registers over an external SPI master using a wrt/done handshake.
- Sits between the SPI master and the integrator; owns all sensor traffic.

Parameters:
- INIT_WAIT_W, 16, width of the power-up wait counter; wait ends when the counter reaches all-ones (2^W - 1 cycles).
- CFG0, 16'h0D02, first config write (data-ready interrupt enable).
- CFG1, 16'h1053, second config write (accel ODR/range).
- CFG2, 16'h1150, third config write (gyro ODR/range).
- CFG3, 16'h1460, fourth config write (rounding).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- INT  input  1  sensor data-ready, asynchronous, level-high
- spi_done  input  1  SPI master transaction complete, 1-cycle pulse
- spi_rd_data  input  16  SPI read data; only [7:0] used
- spi_wrt  output  1  start SPI transaction, 1-cycle pulse
- spi_cmd  output  16  SPI command word
- ptch_rt  output  16  signed raw pitch rate {high,low}
- AZ  output  16  signed raw Z acceleration {high,low}
- vld  output  1  new ptch_rt/AZ valid, 1-cycle pulse

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: spi_wrt=0, spi_cmd=0, ptch_rt=0, AZ=0, vld=0. All state, counters and staging registers are cleared.
- Reset mid-operation aborts any transaction and restarts from PWR_WAIT. Any later spi_done is ignored until a wrt is issued.
- All outputs are registered.
- INT synchronizer: INT passes through two flops; INT_s is the second flop. Only INT_s is used.
- States, in order: PWR_WAIT, CFG_WR(n=0..3), IDLE, RD(k=0..3).
- PWR_WAIT:
  - Counter increments every cycle.
  - When the counter equals all-ones, spi_wrt pulses the next cycle with spi_cmd=CFG0, and the state moves to CFG_WR0.
- CFG_WR(n):
  - The block waits for spi_done.
  - On the edge sampling spi_done=1: if n<3, spi_wrt pulses the next cycle with spi_cmd=CFG(n+1).
  - If n=3, the state moves to IDLE with no wrt.
- IDLE:
  - When INT_s=1 is sampled, spi_wrt pulses the next cycle with spi_cmd=16'hA200, and the state moves to RD0.
- RD(k) commands: k=0 16'hA200 (pitch low), k=1 16'hA300 (pitch high), k=2 16'hACxx→16'hAC00 (AZ low), k=3 16'hAD00 (AZ high).
- RD(k) transitions:
  - On spi_done, spi_rd_data[7:0] is captured into staging byte k.
  - For k<3, wrt pulses the next cycle with the next command.
  - For k=3, the next cycle asserts vld=1 and loads ptch_rt={b1,b0} and AZ={rd_data[7:0],b2}, then the state moves to IDLE.
- Output update rule: ptch_rt and AZ change only in the vld cycle, both together; otherwise they hold.
- Handshake rules:
  - spi_wrt is a single-cycle pulse.
  - spi_cmd is stable from the wrt cycle until the matching spi_done.
  - At most one transaction is outstanding.
  - spi_done in PWR_WAIT or IDLE is ignored (no state change, no capture).
- Latencies:
  - spi_done → next spi_wrt: 1 cycle.
  - final spi_done → vld: 1 cycle.
  - INT rising at the pad → first spi_wrt: 3 clock edges worst case (2 sync + 1).
- INT handling:
  - INT is level-sensitive. If INT_s is still high in IDLE right after vld, a new read starts immediately (the sensor clears INT on read).
  - INT activity during PWR_WAIT, CFG_WR or RD is ignored and does not queue.
- Counter behaviour: the counter does not wrap in PWR_WAIT (the exit happens at all-ones) and is idle thereafter.

Test Plan:
- Power-up/config: INIT_WAIT_W=4, SPI model returns done 8 cycles after each wrt → first wrt at cycle 16 after reset release with cmd 0D02, then 1053, 1150, 1460 each exactly 1 cycle after done. No further wrt while INT=0.
- Read: INT pulsed high; model returns bytes 34,12,CD,AB for A2,A3,AC,AD → commands issued in that order; vld one cycle after fourth done with ptch_rt=16'h1234, AZ=16'hABCD.
- Output holding: ptch_rt/AZ stable outside the vld cycle; a second read returning 00,80,FF,7F → ptch_rt=16'h8000, AZ=16'h7FFF (signed extremes).
- Level INT: INT held high across a full read → second read's A200 wrt issued the cycle after vld; vld pulses exactly once per 4-read burst.
- Spurious done: spi_done pulsed in IDLE and during PWR_WAIT → no wrt, no vld, outputs unchanged.
- Reset mid-read: assert rst_n low after the A300 done → all outputs 0 immediately. After release the block re-runs PWR_WAIT and the full config sequence before any read.
